router_port_receiver: RTL
=========================

Name: router_port_receiver

Overview:
- Sits directly downstream of one router output port; the system instantiates one per port.
- Watches the port's vld_out, drives its read_enb, and drains one packet at a time from the port FIFO.
- Re-times the packet into a valid/ready byte stream with start/end markers, checks parity, and reports per-port statistics.
- Keeps the read-start latency bounded so the router's 30-cycle unread-packet soft reset is never triggered by this block unless intentionally configured to.

Parameters:
- START_DELAY, 0: idle cycles inserted between vld_out rising and the first read_enb (0..63; values ≥30 are for soft-reset testing only).
- CNT_W, 16: width of packet and error counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- port_vld  in  1  router vld_out_x: port FIFO non-empty
- port_data  in  8  router data_out_x; valid one cycle after read_enb
- read_enb  out  1  router read_enb_x
- m_data  out  8  output byte
- m_valid  out  1  output byte valid
- m_sop  out  1  header byte marker, qualified by m_valid
- m_eop  out  1  parity byte marker, qualified by m_valid
- m_ready  in  1  downstream accept
- m_perr  out  1  parity mismatch, valid with m_eop
- busy  out  1  packet in progress (state ≠ IDLE)
- pkt_cnt  out  CNT_W  packets completed, saturating
- perr_cnt  out  CNT_W  parity errors, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: read_enb=0, m_valid=0, m_sop=0, m_eop=0, m_perr=0, busy=0, counters=0, state=IDLE, skid buffer empty. Reset asserted mid-packet discards all buffered and in-flight bytes; after release the block restarts in IDLE.
- Packet format: header (bits[7:2] = payload length L, 1..63; bits[1:0] = address), then L payload bytes, then a parity byte equal to the XOR of the header and all payload bytes. Total bytes = L+2. All bytes are forwarded, including header and parity.
- Read latency: a byte read with read_enb in cycle n is captured from port_data at the edge ending cycle n+1.
- Skid buffer: 2 entries. A read is issued only if (buffer occupancy + reads in flight) < 2 and port_vld=1 and bytes remain to be requested. Captured bytes are pushed into the buffer; the buffer head drives m_*.
- Output handshake: m_data/m_sop/m_eop/m_perr hold stable while m_valid=1 and m_ready=0. Pop on m_valid&m_ready. Push and pop in the same cycle are both allowed.
- States:
  - IDLE: when port_vld=1, go to DELAY if START_DELAY>0, otherwise HDR_RD.
  - DELAY: count START_DELAY cycles, then HDR_RD.
  - HDR_RD: issue exactly one read, then HDR_WT.
  - HDR_WT: on capture, latch L, set remaining = L+1, seed parity accumulator with the header, tag the byte sop, then go to BODY.
  - BODY: issue reads under the credit rule. Each capture XORs into the accumulator. When the final (parity) byte is captured, tag it eop, set m_perr = (accumulator after XOR ≠ 0), then go to DRAIN.
  - DRAIN: wait until the eop byte is popped, then increment pkt_cnt (and perr_cnt if m_perr), then return to IDLE.
- port_vld low mid-packet: stall request issue only; no abort. Bytes already in flight are still captured.
- A header with L=0 is treated as L=1 (no special case). Counters saturate at all-ones.
- Back-to-back packets: the next packet can begin the cycle after DRAIN exits; a new header read is never issued in the same cycle the previous eop byte is popped.

Decomposition:
- Shared router package: packet header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_W=2), maximum payload length of 63, router soft-reset timeout constant of 30, and the state enum.
- One sub-module: router_skid_buf2 (2-entry valid/ready buffer, 11-bit payload {perr,eop,sop,data}).

Test Plan:
- Header 0x0D, payload A1 B2 C3, parity DD, m_ready=1 → m_data stream 0D A1 B2 C3 DD; sop on 0D, eop on DD, m_perr=0; pkt_cnt=1; first read_enb in the cycle after port_vld rises.
- Same packet with parity 0xDC → eop byte shows m_perr=1; perr_cnt=1; pkt_cnt=1.
- Hold m_ready=0 for 10 cycles mid-payload → read_enb stays 0 once 2 credits are used; no bytes are lost or duplicated; the stream resumes in order.
- port_vld toggled low for 3 cycles between payload bytes → read_enb is held 0 during the gap; the packet completes correctly.
- Assert reset during the 2nd payload byte → all outputs return to reset values immediately (asynchronously); the next packet after release (header 0x05, payload 7E, parity 7B) is received cleanly.
- START_DELAY=31 → first read_enb occurs 32 cycles after port_vld rises; confirm the router soft-resets that port and busy returns to 0 once port_vld drops.

Source files
------------

// File: rtl/router_port_receiver_pkg.sv
// Shared router definitions: header field layout, router limits and the
// receiver FSM state encoding.
package router_port_receiver_pkg;

  localparam int unsigned LEN_MSB         = 7;
  localparam int unsigned LEN_LSB         = 2;
  localparam int unsigned ADDR_W          = 2;
  localparam int unsigned MAX_LEN         = 63;
  localparam int unsigned SOFT_RST_CYCLES = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_HDR_RD,
    S_HDR_WT,
    S_BODY,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic       perr;
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } beat_t;

  // Bytes still to come after the header: L payload bytes plus parity.
  // A zero length field is handled as a length of one.
  function automatic logic [6:0] pkt_remaining(input logic [7:0] hdr);
    logic [5:0] len;
    len = hdr[LEN_MSB:LEN_LSB];
    if (len == 6'd0) len = 6'd1;
    return {1'b0, len} + 7'd1;
  endfunction

endpackage

// File: rtl/router_skid_buf2.sv
// Two-entry valid/ready buffer; the head entry drives the output and holds
// stable until it is accepted.
module router_skid_buf2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [10:0] i_data,
  output logic        o_valid,
  output logic [10:0] o_data,
  input  logic        i_ready,
  output logic [1:0]  o_count
);

  logic [10:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign w_pop  = (r_count != 2'd0) && i_ready;
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/router_port_receiver.sv
// Drains one packet at a time from a router output port and re-times it into
// a valid/ready byte stream with sop/eop markers, parity check and counters.
module router_port_receiver
  import router_port_receiver_pkg::*;
#(
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             port_vld,
  input  logic [7:0]       port_data,
  output logic             read_enb,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  input  logic             m_ready,
  output logic             m_perr,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] perr_cnt
);

  localparam logic [5:0] DLY_LAST = (START_DELAY > 0) ? 6'(START_DELAY - 1) : 6'd0;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_dly;
  logic             r_rd_d;
  logic [6:0]       r_req_left;
  logic [6:0]       r_cap_left;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_perr_cnt;
  logic [1:0]       w_occ;
  logic             w_pop;
  logic             w_credit_ok;
  logic             w_last;
  beat_t            w_push_beat;
  beat_t            w_head;

  assign w_pop       = m_valid & m_ready;
  assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_rd_d}) < 3'd2;
  assign w_last      = (r_state == S_BODY) && (r_cap_left == 7'd1);

  always_comb begin
    w_push_beat.data = port_data;
    w_push_beat.sop  = (r_state == S_HDR_WT);
    w_push_beat.eop  = w_last;
    w_push_beat.perr = w_last && ((r_acc ^ port_data) != 8'h00);
  end

  // Losing port_vld before the header read means the router flushed the
  // port (soft reset), so the block falls back to IDLE instead of waiting.
  always_comb begin
    w_next   = r_state;
    read_enb = 1'b0;
    case (r_state)
      S_IDLE:   if (port_vld) w_next = (START_DELAY > 0) ? S_DELAY : S_HDR_RD;
      S_DELAY:  begin
        if (!port_vld)              w_next = S_IDLE;
        else if (r_dly == DLY_LAST) w_next = S_HDR_RD;
      end
      S_HDR_RD: begin
        if (!port_vld) w_next = S_IDLE;
        else begin
          read_enb = 1'b1;
          w_next   = S_HDR_WT;
        end
      end
      S_HDR_WT: if (r_rd_d) w_next = S_BODY;
      S_BODY:   begin
        read_enb = port_vld && (r_req_left != 7'd0) && w_credit_ok;
        if (r_rd_d && w_last) w_next = S_DRAIN;
      end
      S_DRAIN:  if (w_pop && w_head.eop) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dly      <= '0;
      r_rd_d     <= 1'b0;
      r_req_left <= '0;
      r_cap_left <= '0;
      r_acc      <= '0;
      r_pkt_cnt  <= '0;
      r_perr_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_rd_d  <= read_enb;
      r_dly   <= (r_state == S_DELAY) ? r_dly + 6'd1 : 6'd0;

      if (r_state == S_HDR_WT && r_rd_d) begin
        r_acc      <= port_data;
        r_req_left <= pkt_remaining(port_data);
        r_cap_left <= pkt_remaining(port_data);
      end else if (r_state == S_BODY) begin
        if (read_enb) r_req_left <= r_req_left - 7'd1;
        if (r_rd_d) begin
          r_cap_left <= r_cap_left - 7'd1;
          r_acc      <= r_acc ^ port_data;
        end
      end

      if (r_state == S_DRAIN && w_pop && w_head.eop) begin
        if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
        if (w_head.perr && r_perr_cnt != '1) r_perr_cnt <= r_perr_cnt + 1'b1;
      end
    end
  end

  router_skid_buf2 u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_push  (r_rd_d),
    .i_data  (w_push_beat),
    .o_valid (m_valid),
    .o_data  (w_head),
    .i_ready (m_ready),
    .o_count (w_occ)
  );

  assign m_data   = w_head.data;
  assign m_sop    = m_valid & w_head.sop;
  assign m_eop    = m_valid & w_head.eop;
  assign m_perr   = m_valid & w_head.eop & w_head.perr;
  assign busy     = (r_state != S_IDLE);
  assign pkt_cnt  = r_pkt_cnt;
  assign perr_cnt = r_perr_cnt;

endmodule
